// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one string-transmit channel among
// NUM_REQ message sources, with a launch/ack/done sequencer and a watchdog
// that converts a missing tx_done into a per-source error pulse.
//
// state     | meaning
// IDLE      | no owner; pick the next valid source from rr_ptr upward
// LAUNCH    | tx_req high for one cycle (held low for zero-length messages)
// WAIT_ACK  | waiting for tx_busy or an early tx_done
// WAIT_DONE | transmitter busy, waiting for tx_done
// FINISH    | done/err pulse to owner, advance rr_ptr, release grant
module uart_tx_arbiter #(
  parameter int          NUM_REQ     = 4,
  parameter int          STR_W       = 1024,
  parameter int          LEN_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 8_000_000
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*STR_W-1:0] req_string,
  input  logic [NUM_REQ*LEN_W-1:0] req_length,
  output logic [NUM_REQ-1:0]       req_grant,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [NUM_REQ-1:0]       req_err,
  output logic                     arb_busy,
  output logic [STR_W-1:0]         tx_string,
  output logic [LEN_W-1:0]         tx_length,
  output logic                     tx_req,
  input  logic                     tx_busy,
  input  logic                     tx_done
);

  localparam int          IW      = $clog2(NUM_REQ);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, FINISH} state_t;

  state_t         state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  owner;
  logic [31:0]    wdog;
  logic           zero_len;
  logic           win_found;
  logic [IW-1:0]  win_idx;
  logic [IW:0]    probe;
  logic [LEN_W-1:0] win_len;

  // Round-robin search: scan offsets high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    probe     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      probe = {1'b0, rr_ptr} + (IW+1)'(i);
      if (probe >= (IW+1)'(NUM_REQ))
        probe = probe - (IW+1)'(NUM_REQ);
      if (req_valid[probe[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = probe[IW-1:0];
      end
    end
    win_len = req_length[int'(win_idx)*LEN_W +: LEN_W];
  end

  // Arbiter sequencer, watchdog and all registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      wdog      <= '0;
      zero_len  <= 1'b0;
      req_grant <= '0;
      req_done  <= '0;
      req_err   <= '0;
      arb_busy  <= 1'b0;
      tx_string <= '0;
      tx_length <= '0;
      tx_req    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            owner     <= win_idx;
            req_grant <= NUM_REQ'(1) << win_idx;
            tx_string <= req_string[int'(win_idx)*STR_W +: STR_W];
            tx_length <= win_len;
            zero_len  <= (win_len == '0);
            tx_req    <= (win_len != '0);
            arb_busy  <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          // A zero-length message uses this slot without a strobe, so its
          // req_done still lands one cycle after the grant.
          tx_req <= 1'b0;
          wdog   <= '0;
          if (zero_len) begin
            req_done <= req_grant;
            state    <= FINISH;
          end else begin
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK, WAIT_DONE: begin
          if (tx_done) begin
            req_done <= req_grant;
            state    <= FINISH;
          end else if (wdog == WD_LAST) begin
            req_err <= req_grant;
            state   <= FINISH;
          end else begin
            wdog <= wdog + 32'd1;
            if (state == WAIT_ACK && tx_busy)
              state <= WAIT_DONE;
          end
        end
        FINISH: begin
          req_done  <= '0;
          req_err   <= '0;
          req_grant <= '0;
          arb_busy  <= 1'b0;
          rr_ptr    <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single transfer, contention order,
// zero length, watchdog timeout, latched-data stability and async reset.
module tb_uart_tx_arbiter;
  localparam int NQ = 4;
  localparam int SW = 64;
  localparam int LW = 8;
  localparam int TO = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NQ-1:0]     req_valid = '0;
  logic [NQ*SW-1:0]  req_string = '0;
  logic [NQ*LW-1:0]  req_length = '0;
  logic [NQ-1:0]     req_grant, req_done, req_err;
  logic              arb_busy, tx_req;
  logic [SW-1:0]     tx_string;
  logic [LW-1:0]     tx_length;
  logic              tx_busy = 1'b0;
  logic              tx_done = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_arbiter #(.NUM_REQ(NQ), .STR_W(SW), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .req_valid(req_valid), .req_string(req_string), .req_length(req_length),
    .req_grant(req_grant), .req_done(req_done), .req_err(req_err),
    .arb_busy(arb_busy), .tx_string(tx_string), .tx_length(tx_length),
    .tx_req(tx_req), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle with the expected winner already requesting.
  task automatic serve(input int idx, input logic [63:0] exp_str);
    tick;
    chk($sformatf("grant_%0d", idx), 64'(req_grant), 64'(4'b1 << idx));
    chk($sformatf("txreq_%0d", idx), 64'(tx_req), 64'd1);
    chk($sformatf("txstr_%0d", idx), tx_string, exp_str);
    tick;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk($sformatf("done_%0d", idx), 64'(req_done), 64'(4'b1 << idx));
    tick;
  endtask

  initial begin
    int cnt;

    // Reset state
    #2;
    chk("rst_grant", 64'(req_grant), 64'd0);
    chk("rst_busy", 64'(arb_busy), 64'd0);
    chk("rst_txreq", 64'(tx_req), 64'd0);
    tick;
    rst = 1'b0;
    tick;

    // Single request: source 2 sends "OK\r\n"
    req_string[2*SW +: SW] = 64'h0A0D4B4F;
    req_length[2*LW +: LW] = 8'd4;
    req_valid = 4'b0100;
    tick;
    chk("single_txreq", 64'(tx_req), 64'd1);
    chk("single_grant", 64'(req_grant), 64'h4);
    chk("single_str", tx_string, 64'h0A0D4B4F);
    chk("single_len", 64'(tx_length), 64'd4);
    chk("single_busy", 64'(arb_busy), 64'd1);
    tick;
    chk("single_txreq_low", 64'(tx_req), 64'd0);
    tx_busy = 1'b1;
    for (int i = 0; i < 39; i++) tick;
    chk("single_nodone_early", 64'(req_done), 64'd0);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk("single_done", 64'(req_done), 64'h4);
    chk("single_err", 64'(req_err), 64'd0);
    req_valid = 4'b0000;
    tick;
    chk("single_done_clr", 64'(req_done), 64'd0);
    chk("single_grant_clr", 64'(req_grant), 64'd0);
    chk("single_idle", 64'(arb_busy), 64'd0);

    // Contention from reset: order 0,1,2,3 then re-requesting 0
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      req_string[i*SW +: SW] = 64'h1000 + 64'(i);
      req_length[i*LW +: LW] = 8'd3;
    end
    req_valid = 4'b1111;
    serve(0, 64'h1000);
    req_string[0*SW +: SW] = 64'h2000;
    serve(1, 64'h1001);
    req_valid[1] = 1'b0;
    serve(2, 64'h1002);
    req_valid[2] = 1'b0;
    serve(3, 64'h1003);
    req_valid[3] = 1'b0;
    serve(0, 64'h2000);
    req_valid = 4'b0000;

    // Zero length on source 1 (rr_ptr now 1)
    req_length[1*LW +: LW] = 8'd0;
    req_valid = 4'b0010;
    tick;
    chk("zero_grant", 64'(req_grant), 64'h2);
    chk("zero_txreq1", 64'(tx_req), 64'd0);
    chk("zero_nodone1", 64'(req_done), 64'd0);
    tick;
    chk("zero_done", 64'(req_done), 64'h2);
    chk("zero_txreq2", 64'(tx_req), 64'd0);
    req_valid = 4'b0000;
    tick;
    chk("zero_grant_clr", 64'(req_grant), 64'd0);
    req_length[1*LW +: LW] = 8'd5;

    // Timeout on source 3 (rr_ptr now 2), source 0 pending behind it
    req_valid = 4'b1001;
    tick;
    chk("to_grant", 64'(req_grant), 64'h8);
    chk("to_txreq", 64'(tx_req), 64'd1);
    tick;
    tx_busy = 1'b1;
    cnt = 0;
    for (int i = 2; i <= 200; i++) begin
      tick;
      if (req_err != '0) begin
        cnt = i;
        break;
      end
    end
    chk("to_latency", 64'(cnt), 64'(TO + 1));
    chk("to_err", 64'(req_err), 64'h8);
    chk("to_nodone", 64'(req_done), 64'd0);
    tx_busy = 1'b0;
    req_valid = 4'b0001;
    tick;
    chk("to_err_clr", 64'(req_err), 64'd0);
    tick;
    chk("to_next_grant", 64'(req_grant), 64'h1);
    chk("to_next_txreq", 64'(tx_req), 64'd1);
    tick;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk("to_next_done", 64'(req_done), 64'h1);
    req_valid = 4'b0000;
    tick;

    // Data stability on source 2 (rr_ptr now 1)
    req_string[2*SW +: SW] = 64'hCAFE;
    req_length[2*LW +: LW] = 8'd7;
    req_valid = 4'b0100;
    tick;
    chk("stab_str0", tx_string, 64'hCAFE);
    tick;
    tx_busy = 1'b1;
    req_string[2*SW +: SW] = 64'hDEAD;
    req_length[2*LW +: LW] = 8'd9;
    req_valid = 4'b0000;
    for (int i = 0; i < 5; i++) tick;
    chk("stab_str", tx_string, 64'hCAFE);
    chk("stab_len", 64'(tx_length), 64'd7);
    chk("stab_grant", 64'(req_grant), 64'h4);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk("stab_done", 64'(req_done), 64'h4);
    chk("stab_str_fin", tx_string, 64'hCAFE);
    tick;

    // Reset in WAIT_DONE while source 3 owns (rr_ptr now 3)
    req_valid = 4'b1011;
    tick;
    chk("rstm_grant", 64'(req_grant), 64'h8);
    tick;
    tx_busy = 1'b1;
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk("rstm_grant0", 64'(req_grant), 64'd0);
    chk("rstm_busy0", 64'(arb_busy), 64'd0);
    chk("rstm_str0", tx_string, 64'd0);
    chk("rstm_len0", 64'(tx_length), 64'd0);
    chk("rstm_txreq0", 64'(tx_req), 64'd0);
    tick;
    rst = 1'b0;
    tx_busy = 1'b0;
    tick;
    chk("rstm_restart_grant", 64'(req_grant), 64'h1);
    chk("rstm_restart_txreq", 64'(tx_req), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
